// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result channels of alu_pipe.
//   master (issuer):  drives in_valid, op, sr, tr, sh, imm, out_ready;
//                     sees in_ready, out_valid, dr, wen, flags.
//   slave (alu_pipe): the mirror image.
//   flags are {Z,S,C,V}.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IMMW  = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] tr;
   logic [7:0]       sh;
   logic [IMMW-1:0]  imm;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dr;
   logic             wen;
   logic [3:0]       flags;

   modport master (
      output in_valid, op, sr, tr, sh, imm, out_ready,
      input  in_ready, out_valid, dr, wen, flags
   );

   modport slave (
      input  in_valid, op, sr, tr, sh, imm, out_ready,
      output in_ready, out_valid, dr, wen, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU between register-read and writeback.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_pipe_if.slave: op/sr/tr/sh/imm offered on in_valid/in_ready,
//        dr/wen/flags{Z,S,C,V} returned on out_valid/out_ready.
// Single-cycle ops return one cycle after accept. With ALU_MUL_EN defined,
// op 14 is an iterative shift-add multiply (WIDTH steps in BUSY); without it,
// op 14 behaves as the reserved op.
module alu_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IMMW  = 16
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [3:0] OP_MOV = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_CMP = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NEG = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_SLL = 4'd9;
   localparam logic [3:0] OP_SLA = 4'd10;
   localparam logic [3:0] OP_SRL = 4'd11;
   localparam logic [3:0] OP_SRA = 4'd12;
   localparam logic [3:0] OP_LIL = 4'd13;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd14;
   localparam int unsigned CNTW = $clog2(WIDTH);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
      S_BUSY = 2'd2,
`endif
      S_DONE = 2'd1
   } state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] dr_q, dr_d;
   logic             wen_q, wen_d;
   logic [3:0]       flags_q, flags_d;
   logic             in_ready_c;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] mul_sum_c;
   logic             is_mul_c;
`endif

   logic [WIDTH-1:0] alu_dr_c;
   logic             alu_wen_c, alu_c_c, alu_v_c;
   logic [WIDTH:0]   sum_c, diff_c;
   logic             sh_big_c;

   // Flags are derived from the final result plus op-specific carry/overflow.
   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
      return {(r == '0), r[MSB], c, v};
   endfunction

   // Single-cycle datapath; unlisted codes (reserved) yield 0 with wen=0.
   always_comb begin
      sum_c     = {1'b0, bus.tr} + {1'b0, bus.sr};
      diff_c    = {1'b0, bus.tr} - {1'b0, bus.sr};   // top bit = borrow
      sh_big_c  = (32'(bus.sh) >= WIDTH);
      alu_dr_c  = '0;
      alu_wen_c = 1'b1;
      alu_c_c   = 1'b0;
      alu_v_c   = 1'b0;
      case (bus.op)
         OP_MOV: alu_dr_c = bus.sr;
         OP_ADD: begin
            alu_dr_c = sum_c[MSB:0];
            alu_c_c  = sum_c[WIDTH];
            alu_v_c  = (bus.tr[MSB] == bus.sr[MSB]) && (sum_c[MSB] != bus.tr[MSB]);
         end
         OP_SUB, OP_CMP: begin
            alu_dr_c  = diff_c[MSB:0];
            alu_c_c   = diff_c[WIDTH];
            alu_v_c   = (bus.tr[MSB] != bus.sr[MSB]) && (diff_c[MSB] != bus.tr[MSB]);
            alu_wen_c = (bus.op == OP_SUB);
         end
         OP_AND: alu_dr_c = bus.tr & bus.sr;
         OP_OR:  alu_dr_c = bus.tr | bus.sr;
         OP_XOR: alu_dr_c = bus.tr ^ bus.sr;
         OP_NEG: alu_dr_c = ~bus.tr + WIDTH'(1);
         OP_NOT: alu_dr_c = ~bus.tr;
         OP_SLL, OP_SLA: alu_dr_c = sh_big_c ? '0 : (bus.tr << bus.sh);
         OP_SRL: alu_dr_c = sh_big_c ? '0 : (bus.tr >> bus.sh);
         OP_SRA: alu_dr_c = sh_big_c ? {WIDTH{bus.tr[MSB]}}
                                     : WIDTH'($signed(bus.tr) >>> bus.sh);
         OP_LIL: alu_dr_c = WIDTH'(bus.imm);
         default: alu_wen_c = 1'b0;
      endcase
   end

   // Next-state and handshake logic; acceptance overrides DONE->IDLE so
   // back-to-back ops proceed without a bubble.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      dr_d        = dr_q;
      wen_d       = wen_q;
      flags_d     = flags_q;
      in_ready_c  = 1'b0;
`ifdef ALU_MUL_EN
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      mul_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
      is_mul_c  = (bus.op == OP_MUL);
`endif
      case (state_q)
         S_IDLE: in_ready_c = 1'b1;
         S_DONE: begin
            in_ready_c = bus.out_ready;
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
`ifdef ALU_MUL_EN
         S_BUSY: begin
            acc_d    = mul_sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
               dr_d        = mul_sum_c;
               wen_d       = 1'b1;
               flags_d     = mk_flags(mul_sum_c, 1'b0, 1'b0);
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (in_ready_c && bus.in_valid) begin
`ifdef ALU_MUL_EN
         if (is_mul_c) begin
            mcand_d     = bus.tr;
            mplier_d    = bus.sr;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = S_BUSY;
         end else
`endif
         begin
            dr_d        = alu_dr_c;
            wen_d       = alu_wen_c;
            flags_d     = mk_flags(alu_dr_c, alu_c_c, alu_v_c);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
      end
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         dr_q        <= '0;
         wen_q       <= 1'b0;
         flags_q     <= '0;
`ifdef ALU_MUL_EN
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         dr_q        <= dr_d;
         wen_q       <= wen_d;
         flags_q     <= flags_d;
`ifdef ALU_MUL_EN
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.dr        = dr_q;
   assign bus.wen       = wen_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe (WIDTH=32, IMMW=16).
// The issuing process pushes the hand-computed result of each accepted op;
// an independent monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_alu_pipe;
   localparam int unsigned W = 32;

   typedef struct packed {
      logic [31:0] dr;
      logic        wen;
      logic [3:0]  flags;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(W), .IMMW(16)) bus ();
   alu_pipe #(.WIDTH(W), .IMMW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%08h want=0x%08h", name, got, want);
      end
   endtask

   // Monitor: compares every presented-and-accepted result against the queue.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (!rst && bus.out_valid && bus.out_ready) begin
         got = {bus.dr, bus.wen, bus.flags};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result got dr=0x%08h wen=%0b flags=%04b",
                     bus.dr, bus.wen, bus.flags);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL result got dr=0x%08h wen=%0b flags=%04b want dr=0x%08h wen=%0b flags=%04b",
                        got.dr, got.wen, got.flags, e.dr, e.wen, e.flags);
            end
         end
      end
   end

   // Offers one op, records its expected result at acceptance, then scrambles
   // the inputs to show they are not re-sampled.
   task automatic send(input logic [3:0] op, input logic [31:0] tr, input logic [31:0] sr,
                       input logic [7:0] sh, input logic [15:0] imm,
                       input logic [31:0] edr, input logic ewen, input logic [3:0] efl);
      int n = 0;
      bus.op = op; bus.tr = tr; bus.sr = sr; bus.sh = sh; bus.imm = imm;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      else exp_q.push_back('{dr: edr, wen: ewen, flags: efl});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.tr  = $urandom();
      bus.sr  = $urandom();
      bus.sh  = 8'($urandom());
      bus.imm = 16'($urandom());
      bus.op  = 4'($urandom());
   endtask

   // Waits until all expected results have been consumed, then past the edge.
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      int busy;
      bus.in_valid = 1'b0; bus.op = 4'd0; bus.sr = '0; bus.tr = '0;
      bus.sh = 8'd0; bus.imm = 16'd0; bus.out_ready = 1'b1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_dr",        bus.dr,             32'd0);
      chk("rst_wen",       32'(bus.wen),       32'd0);
      chk("rst_flags",     32'(bus.flags),     32'd0);
      @(posedge clk);
      #1;

      send(4'd1, 32'h7FFF_FFFF, 32'h1, 8'd0, 16'h0, 32'h8000_0000, 1'b1, 4'b0101);
      @(negedge clk);
      chk("add_latency", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;

      // op, tr, sr, sh, imm -> dr, wen, {Z,S,C,V}
      send(4'd3,  32'h0,         32'h1,         8'd0,  16'h0,    32'hFFFF_FFFF, 1'b0, 4'b0110);
      send(4'd3,  32'h5,         32'h5,         8'd0,  16'h0,    32'h0,         1'b0, 4'b1000);
      send(4'd12, 32'h8000_0000, 32'h0,         8'd40, 16'h0,    32'hFFFF_FFFF, 1'b1, 4'b0100);
      send(4'd12, 32'h8000_0000, 32'h0,         8'd4,  16'h0,    32'hF800_0000, 1'b1, 4'b0100);
      send(4'd11, 32'hFFFF_FFFF, 32'h0,         8'd32, 16'h0,    32'h0,         1'b1, 4'b1000);
      send(4'd13, 32'h0,         32'h0,         8'd0,  16'hBEEF, 32'h0000_BEEF, 1'b1, 4'b0000);
      send(4'd2,  32'h3,         32'h5,         8'd0,  16'h0,    32'hFFFF_FFFE, 1'b1, 4'b0110);
      send(4'd2,  32'h8000_0000, 32'h1,         8'd0,  16'h0,    32'h7FFF_FFFF, 1'b1, 4'b0001);
      send(4'd0,  32'h0,         32'h1234_5678, 8'd0,  16'h0,    32'h1234_5678, 1'b1, 4'b0000);
      send(4'd7,  32'h1,         32'h0,         8'd0,  16'h0,    32'hFFFF_FFFF, 1'b1, 4'b0100);
      send(4'd8,  32'h0,         32'h0,         8'd0,  16'h0,    32'hFFFF_FFFF, 1'b1, 4'b0100);
      send(4'd9,  32'h1,         32'h0,         8'd31, 16'h0,    32'h8000_0000, 1'b1, 4'b0100);
      send(4'd10, 32'h1234,      32'h0,         8'd0,  16'h0,    32'h0000_1234, 1'b1, 4'b0000);
      send(4'd5,  32'hF0,        32'h0F,        8'd0,  16'h0,    32'h0000_00FF, 1'b1, 4'b0000);
      send(4'd1,  32'hFFFF_FFFF, 32'h1,         8'd0,  16'h0,    32'h0,         1'b1, 4'b1010);
      send(4'd15, 32'h1234,      32'h5678,      8'd3,  16'h1,    32'h0,         1'b0, 4'b1000);

`ifdef ALU_MUL_EN
      drain();
      send(4'd14, 32'h0001_0000, 32'h0001_0000, 8'd0, 16'h0, 32'h0, 1'b1, 4'b1000);
      cyc = 0;
      busy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!bus.in_ready) busy++;
      end while (!bus.out_valid && cyc < 100);
      chk("mul_busy_cycles", 32'(busy), 32'd32);
      chk("mul_out_cycle",   32'(cyc),  32'd33);
      @(posedge clk);
      #1;
      send(4'd14, 32'hFFFF_FFFF, 32'h3, 8'd0, 16'h0, 32'hFFFF_FFFD, 1'b1, 4'b0100);
`else
      send(4'd14, 32'hFFFF_FFFF, 32'h3, 8'd0, 16'h0, 32'h0, 1'b0, 4'b1000);
      @(negedge clk);
      chk("op14_latency", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
`endif

      // Backpressure: AND result held for 5 cycles, then XOR accepted on release.
      drain();
      bus.out_ready = 1'b0;
      send(4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 8'd0, 16'h0, 32'h0F00_0F00, 1'b1, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_dr",        bus.dr,             32'h0F00_0F00);
         chk("stall_flags",     32'(bus.flags),     32'd0);
         chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 8'd0, 16'h0, 32'h5555_5555, 1'b1, 4'b0000);
      @(negedge clk);
      chk("no_bubble", 32'(bus.out_valid), 32'd1);
      drain();

      // Reset with an op in flight discards it.
`ifdef ALU_MUL_EN
      send(4'd14, 32'h5, 32'h7, 8'd0, 16'h0, 32'h23, 1'b1, 4'b0000);
      repeat (10) @(negedge clk);
      chk("busy_in_ready",  32'(bus.in_ready),  32'd0);
      chk("busy_out_valid", 32'(bus.out_valid), 32'd0);
`else
      bus.out_ready = 1'b0;
      send(4'd1, 32'h1, 32'h2, 8'd0, 16'h0, 32'h3, 1'b1, 4'b0000);
      repeat (2) @(negedge clk);
      chk("held_out_valid", 32'(bus.out_valid), 32'd1);
`endif
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst2_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst2_dr",        bus.dr,             32'd0);
      @(posedge clk);
      #1;
      send(4'd1, 32'h2, 32'h3, 8'd0, 16'h0, 32'h5, 1'b1, 4'b0000);
      drain();

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
